// File: rtl/psum_sram_arbiter_if.sv
// Requester-side bus of the partial-sum SRAM arbiter.
// The master modport is the requester group (OFIFO, SFU, host); the slave modport is the arbiter.
// Bit 0 = OFIFO, bit 1 = SFU, bit 2 = host in every 3-bit field.
interface psum_sram_arbiter_if #(
    parameter int psum_bw = 13,
    parameter int col     = 8,
    parameter int ADDR_W  = 11
);
    logic [2:0]             req;
    logic [2:0]             wr;
    logic [ADDR_W-1:0]      addr0;
    logic [ADDR_W-1:0]      addr1;
    logic [ADDR_W-1:0]      addr2;
    logic [psum_bw*col-1:0] wdata0;
    logic [psum_bw*col-1:0] wdata1;
    logic                   sfu_lock;
    logic [2:0]             gnt;
    logic [2:0]             rd_valid;
    logic [psum_bw*col-1:0] rdata;

    modport master (
        output req, wr, addr0, addr1, addr2, wdata0, wdata1, sfu_lock,
        input  gnt, rd_valid, rdata
    );

    modport slave (
        input  req, wr, addr0, addr1, addr2, wdata0, wdata1, sfu_lock,
        output gnt, rd_valid, rdata
    );
endinterface

// File: rtl/psum_sram_arbiter.sv
// Single-port partial-sum SRAM arbiter for OFIFO writeback, SFU read-modify-write
// and host readout. Grants are combinational (zero-latency when uncontested);
// read returns are tagged one cycle after the grant to match the SRAM read latency.
// The SFU may hold the SRAM exclusively with sfu_lock (LOCKED state).
// Optional feature macro: PSUM_ARB_RR_EN -- round-robin arbitration in IDLE
// (default build: fixed priority OFIFO > SFU > host, no pointer register).
module psum_sram_arbiter #(
    parameter int psum_bw = 13,
    parameter int col     = 8,
    parameter int ADDR_W  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    psum_sram_arbiter_if.slave     bus,
    output logic                   CEN,
    output logic                   WEN,
    output logic [ADDR_W-1:0]      A,
    output logic [psum_bw*col-1:0] D,
    input  logic [psum_bw*col-1:0] Q,
    output logic                   locked,
    output logic [15:0]            conflict_cnt
);
    localparam int DW = psum_bw * col;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t      r_state;
    logic [2:0]  r_rd_tag;
    logic [15:0] r_conflict_cnt;

    logic              w_lock_mode;
    logic [2:0]        w_gnt;
    logic              w_wr_grant;
    logic              w_conflict;
    logic [ADDR_W-1:0] w_addr;
    logic [DW-1:0]     w_wdata;
    logic              w_unused;

    // Number of simultaneously asserted requests (0..3).
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // First requester in bit order 0, 1, 2 wins.
    function automatic logic [2:0] fixed_pick(input logic [2:0] rq);
        logic [2:0] g;
        g = 3'b000;
        if (rq[0]) begin
            g = 3'b001;
        end else if (rq[1]) begin
            g = 3'b010;
        end else if (rq[2]) begin
            g = 3'b100;
        end else begin
            g = 3'b000;
        end
        return g;
    endfunction

`ifdef PSUM_ARB_RR_EN
    logic [1:0] r_rr_ptr;

    // Rotate requests so the pointed-to requester sits at bit 0, pick, rotate back.
    function automatic logic [2:0] rr_pick(input logic [2:0] rq, input logic [1:0] ptr);
        logic [2:0] rot;
        logic [2:0] g;
        case (ptr)
            2'd1:    rot = {rq[0], rq[2], rq[1]};
            2'd2:    rot = {rq[1], rq[0], rq[2]};
            default: rot = rq;
        endcase
        g = fixed_pick(rot);
        case (ptr)
            2'd1:    return {g[1], g[0], g[2]};
            2'd2:    return {g[0], g[2], g[1]};
            default: return g;
        endcase
    endfunction
`endif

    // wr[2] has no meaning: the host port is read-only.
    assign w_unused    = bus.wr[2];
    // Lock rules apply only while the SFU keeps sfu_lock high; on release the same cycle arbitrates normally.
    assign w_lock_mode = (r_state == ST_LOCKED) && bus.sfu_lock;

    // Grant selection: forced off in reset, SFU-only while locked, otherwise IDLE arbitration.
    always_comb begin
        w_gnt = 3'b000;
        if (reset) begin
            w_gnt = 3'b000;
        end else if (w_lock_mode) begin
            if (bus.req[1]) begin
                w_gnt = 3'b010;
            end else begin
                w_gnt = 3'b000;
            end
        end else begin
`ifdef PSUM_ARB_RR_EN
            w_gnt = rr_pick(bus.req, r_rr_ptr);
`else
            w_gnt = fixed_pick(bus.req);
`endif
        end
    end

    // SRAM address/data mux from the granted requester; data is zero unless writing.
    always_comb begin
        w_addr     = {ADDR_W{1'b0}};
        w_wdata    = {DW{1'b0}};
        w_wr_grant = 1'b0;
        case (w_gnt)
            3'b001: begin
                w_addr     = bus.addr0;
                w_wr_grant = bus.wr[0];
                if (bus.wr[0]) begin
                    w_wdata = bus.wdata0;
                end else begin
                    w_wdata = {DW{1'b0}};
                end
            end
            3'b010: begin
                w_addr     = bus.addr1;
                w_wr_grant = bus.wr[1];
                if (bus.wr[1]) begin
                    w_wdata = bus.wdata1;
                end else begin
                    w_wdata = {DW{1'b0}};
                end
            end
            3'b100: begin
                w_addr = bus.addr2;
            end
            default: begin
                w_addr     = {ADDR_W{1'b0}};
                w_wdata    = {DW{1'b0}};
                w_wr_grant = 1'b0;
            end
        endcase
    end

    // Contention: two or more requesters at once, or OFIFO/host knocking while the SFU holds the lock.
    assign w_conflict = (popcount3(bus.req) >= 2'd2) ||
                        ((r_state == ST_LOCKED) && (bus.req[0] || bus.req[2]));

    // FSM state and read-return tag; reset cancels a pending return and drops the lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rd_tag <= 3'b000;
        end else begin
            r_rd_tag <= w_gnt & ~{1'b0, bus.wr[1:0]};
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt[1] && bus.sfu_lock) begin
                        r_state <= ST_LOCKED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (bus.sfu_lock) begin
                        r_state <= ST_LOCKED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of contended cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= 16'h0000;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end else begin
            r_conflict_cnt <= r_conflict_cnt;
        end
    end

`ifdef PSUM_ARB_RR_EN
    // Round-robin pointer: the requester after the one just granted becomes highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else begin
            case (w_gnt)
                3'b001:  r_rr_ptr <= 2'd1;
                3'b010:  r_rr_ptr <= 2'd2;
                3'b100:  r_rr_ptr <= 2'd0;
                default: r_rr_ptr <= r_rr_ptr;
            endcase
        end
    end
`endif

    // Output drive; a read tag pending when reset rises is suppressed immediately.
    always_comb begin
        bus.gnt      = w_gnt;
        bus.rd_valid = r_rd_tag & {3{~reset}};
        bus.rdata    = Q;
        CEN          = ~(|w_gnt);
        WEN          = ~w_wr_grant;
        A            = w_addr;
        D            = w_wdata;
        locked       = (r_state == ST_LOCKED) && !reset;
        conflict_cnt = r_conflict_cnt;
    end
endmodule

// File: tb/tb_psum_sram_arbiter.sv
// Bench for psum_sram_arbiter: directed steps followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_psum_sram_arbiter;
    localparam int PB  = 13;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int DW  = PB * COL;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          CEN;
    logic          WEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [DW-1:0] Q = '0;
    logic          locked;
    logic [15:0]   conflict_cnt;

    psum_sram_arbiter_if #(.psum_bw(PB), .col(COL), .ADDR_W(AW)) bus ();

    psum_sram_arbiter #(.psum_bw(PB), .col(COL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q),
        .locked(locked), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // SRAM instance model, driven by the arbiter's pins.
    logic [DW-1:0] sram [0:2047];
    always @(posedge clk) begin
        if (!CEN) begin
            if (!WEN) sram[A] <= D;
            else      Q <= sram[A];
        end
    end

    // Reference model state.
    bit            m_locked;
    int            m_ptr;
    int            m_cnt;
    logic [2:0]    m_rdv;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] mmem [0:2047];

    int total = 0;
    int bad   = 0;

    // Last observed DUT values (captured at the sample point).
    logic [2:0]    o_gnt, o_rdv;
    logic          o_cen, o_wen, o_locked;
    logic [AW-1:0] o_a;
    logic [DW-1:0] o_rdata;
    logic [15:0]   o_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Who should win this cycle, from the arbitration rules.
    function automatic logic [2:0] model_gnt();
        int idx;
        if (reset) return 3'b000;
        if (m_locked && bus.sfu_lock) return bus.req[1] ? 3'b010 : 3'b000;
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (bus.req[idx]) return 3'b001 << idx;
        end
        return 3'b000;
    endfunction

    // One clock: sample at the falling edge, compare, advance the model, step past the rising edge.
    task automatic cyc(input bit check);
        logic [2:0]    eg, erv;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int            gi;
        @(negedge clk);
        eg = model_gnt();
        gi = -1;
        for (int i = 0; i < 3; i++) if (eg[i]) gi = i;
        ew = (gi == 0 && bus.wr[0]) || (gi == 1 && bus.wr[1]);
        ea = '0;
        ed = '0;
        if (gi == 0) ea = bus.addr0;
        else if (gi == 1) ea = bus.addr1;
        else if (gi == 2) ea = bus.addr2;
        if (ew) ed = (gi == 0) ? bus.wdata0 : bus.wdata1;
        erv = reset ? 3'b000 : m_rdv;
        o_gnt = bus.gnt; o_rdv = bus.rd_valid; o_cen = CEN; o_wen = WEN;
        o_a = A; o_rdata = bus.rdata; o_locked = locked; o_cnt = conflict_cnt;
        if (check) begin
            chk("gnt", 128'(bus.gnt), 128'(eg));
            chk("CEN", 128'(CEN), 128'(gi < 0));
            chk("WEN", 128'(WEN), 128'(!ew));
            chk("A", 128'(A), 128'(ea));
            chk("D", 128'(D), 128'(ed));
            chk("rd_valid", 128'(bus.rd_valid), 128'(erv));
            chk("locked", 128'(locked), 128'(!reset && m_locked));
            chk("conflict_cnt", 128'(conflict_cnt), 128'(m_cnt));
            if (erv != 3'b000) chk("rdata", 128'(bus.rdata), 128'(m_rdata));
        end
        if (reset) begin
            m_locked = 1'b0; m_ptr = 0; m_cnt = 0; m_rdv = 3'b000;
        end else begin
            if ($countones(bus.req) >= 2 || (m_locked && (bus.req[0] || bus.req[2]))) begin
                if (m_cnt < 65535) m_cnt++;
            end
            m_rdv = 3'b000;
            if (gi >= 0) begin
                if (ew) mmem[ea] = ed;
                else begin
                    m_rdv   = eg;
                    m_rdata = mmem[ea];
                end
`ifdef PSUM_ARB_RR_EN
                m_ptr = (gi + 1) % 3;
`endif
            end
            m_locked = (m_locked && bus.sfu_lock) || (eg == 3'b010 && bus.sfu_lock);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] pre;
        logic [DW-1:0] wv;
        for (int i = 0; i < 2048; i++) begin
            sram[i] = '0;
            mmem[i] = '0;
        end
        m_locked = 1'b0; m_ptr = 0; m_cnt = 0; m_rdv = 3'b000; m_rdata = '0;
        bus.req = 3'b000; bus.wr = 3'b000; bus.sfu_lock = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        pre = {COL{13'h1234}};
        sram[5] = pre;
        mmem[5] = pre;

        // Reset: first cycle unchecked (registers not yet defined), second checked.
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        chk("rst_gnt", 128'(o_gnt), 128'(3'b000));
        chk("rst_cen", 128'(o_cen), 128'(1'b1));
        chk("rst_cnt", 128'(o_cnt), 128'(16'h0000));
        reset = 1'b0;

        // Host read of preloaded address 5.
        bus.req = 3'b100; bus.addr2 = 11'd5;
        cyc(1'b1);
        chk("t1_gnt", 128'(o_gnt), 128'(3'b100));
        chk("t1_cen", 128'(o_cen), 128'(1'b0));
        chk("t1_wen", 128'(o_wen), 128'(1'b1));
        chk("t1_a", 128'(o_a), 128'(11'd5));
        bus.req = 3'b000;
        cyc(1'b1);
        chk("t1_rdv", 128'(o_rdv), 128'(3'b100));
        chk("t1_rdata", 128'(o_rdata), 128'(pre));

        // OFIFO write and host read of the same address in one cycle.
        wv = rnd_word();
        bus.req = 3'b101; bus.wr = 3'b001; bus.addr0 = 11'd3; bus.addr2 = 11'd3; bus.wdata0 = wv;
        cyc(1'b1);
        chk("t2_gnt0", 128'(o_gnt), 128'(3'b001));
        chk("t2_wen", 128'(o_wen), 128'(1'b0));
        bus.req = 3'b100; bus.wr = 3'b000;
        cyc(1'b1);
        chk("t2_gnt2", 128'(o_gnt), 128'(3'b100));
        chk("t2_cnt", 128'(o_cnt), 128'(16'd1));
        bus.req = 3'b000;
        cyc(1'b1);
        chk("t2_rdv", 128'(o_rdv), 128'(3'b100));
        chk("t2_rdata", 128'(o_rdata), 128'(wv));

        // SFU lock: read, then write while OFIFO waits, then release.
        bus.req = 3'b010; bus.wr = 3'b000; bus.addr1 = 11'd7; bus.sfu_lock = 1'b1;
        cyc(1'b1);
        chk("t3_gnt_rd", 128'(o_gnt), 128'(3'b010));
        bus.req = 3'b011; bus.wr = 3'b011; bus.addr0 = 11'd9; bus.wdata0 = rnd_word(); bus.wdata1 = rnd_word();
        cyc(1'b1);
        chk("t3_gnt_wr", 128'(o_gnt), 128'(3'b010));
        chk("t3_locked", 128'(o_locked), 128'(1'b1));
        bus.req = 3'b001;
        cyc(1'b1);
        chk("t3_blocked", 128'(o_gnt), 128'(3'b000));
        bus.sfu_lock = 1'b0;
        cyc(1'b1);
        chk("t3_release", 128'(o_gnt), 128'(3'b001));
        bus.req = 3'b000;
        cyc(1'b1);
        chk("t3_unlocked", 128'(o_locked), 128'(1'b0));

        // sfu_lock rising together with an OFIFO request: OFIFO wins, no lock.
        bus.req = 3'b011; bus.wr = 3'b000; bus.sfu_lock = 1'b1;
        cyc(1'b1);
        chk("t4_ofifo", 128'(o_gnt), 128'(3'b001));
        bus.req = 3'b000;
        cyc(1'b1);
        chk("t4_nolock", 128'(o_locked), 128'(1'b0));
        // sfu_lock without an SFU request does nothing.
        cyc(1'b1);
        chk("t4_idle_lock", 128'(o_locked), 128'(1'b0));
        bus.sfu_lock = 1'b0;

        // Priority ordering with all three requesting.
        reset = 1'b1; cyc(1'b1); reset = 1'b0;
        bus.wr = 3'b000;
        bus.req = 3'b111; cyc(1'b1);
`ifndef PSUM_ARB_RR_EN
        chk("t5_g0", 128'(o_gnt), 128'(3'b001));
`endif
        cyc(1'b1);
`ifndef PSUM_ARB_RR_EN
        chk("t5_g1", 128'(o_gnt), 128'(3'b001));
`endif
        bus.req = 3'b110; cyc(1'b1);
`ifndef PSUM_ARB_RR_EN
        chk("t5_g2", 128'(o_gnt), 128'(3'b010));
`endif
        cyc(1'b1);
`ifndef PSUM_ARB_RR_EN
        chk("t5_g3", 128'(o_gnt), 128'(3'b010));
`endif
        bus.req = 3'b100; cyc(1'b1);
        chk("t5_host", 128'(o_gnt), 128'(3'b100));

`ifdef PSUM_ARB_RR_EN
        // Round-robin rotation from a freshly reset pointer.
        reset = 1'b1; bus.req = 3'b000; cyc(1'b1); reset = 1'b0;
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1);
            chk("t6_rr", 128'(o_gnt), 128'(3'b001 << (k % 3)));
        end
`endif

        // Reset right after a granted host read.
        bus.req = 3'b101; bus.wr = 3'b000; cyc(1'b1);
        bus.req = 3'b100; bus.addr2 = 11'd5; cyc(1'b1);
        reset = 1'b1;
        cyc(1'b1);
        chk("t7_rdv", 128'(o_rdv), 128'(3'b000));
        chk("t7_gnt", 128'(o_gnt), 128'(3'b000));
        chk("t7_cen", 128'(o_cen), 128'(1'b1));
        reset = 1'b0; bus.req = 3'b000;
        cyc(1'b1);
        chk("t7_cnt", 128'(o_cnt), 128'(16'h0000));
        chk("t7_rdv2", 128'(o_rdv), 128'(3'b000));

        // Randomized traffic, small address range to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            bus.req      = 3'($urandom_range(0, 7));
            bus.wr       = 3'($urandom_range(0, 7));
            bus.addr0    = AW'($urandom_range(0, 7));
            bus.addr1    = AW'($urandom_range(0, 7));
            bus.addr2    = AW'($urandom_range(0, 7));
            bus.wdata0   = rnd_word();
            bus.wdata1   = rnd_word();
            bus.sfu_lock = ($urandom_range(0, 3) != 0);
            cyc(1'b1);
        end

        // Counter saturation.
        reset = 1'b1; bus.req = 3'b000; bus.sfu_lock = 1'b0; cyc(1'b1); reset = 1'b0;
        bus.req = 3'b011; bus.wr = 3'b000;
        for (int n = 0; n < 65536; n++) cyc(1'b0);
        cyc(1'b1);
        chk("sat_cnt", 128'(o_cnt), 128'(16'hFFFF));
        cyc(1'b1);
        chk("sat_hold", 128'(o_cnt), 128'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
